// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 5..MAX_DATA_BITS data, none/even/odd parity, 1 or 2 stop
// bits, framing/break/overrun reporting and a valid/ready word output.
module uart_rx_cfg #(
  parameter int unsigned MAX_DATA_BITS = 8,
  parameter int unsigned OVERSAMPLE    = 16,
  parameter int unsigned TIMER_BITS    = 11
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [TIMER_BITS-1:0]    timer_final_value,
  input  logic [3:0]               cfg_data_bits,
  input  logic [1:0]               cfg_parity,
  input  logic                     cfg_stop_bits,
  input  logic                     rx,
  output logic [MAX_DATA_BITS-1:0] r_data,
  output logic                     r_valid,
  input  logic                     r_ready,
  output logic                     parity_error,
  output logic                     framing_error,
  output logic                     break_detect,
  output logic                     overrun,
  output logic                     busy
);

  localparam int unsigned TcntW = $clog2(OVERSAMPLE);
  localparam logic [TcntW-1:0] TcntHalf = TcntW'(OVERSAMPLE / 2 - 1);
  localparam logic [TcntW-1:0] TcntLast = TcntW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBrkWait} state_e;

  logic                     rx_meta, rx_s;
  logic [TIMER_BITS-1:0]    tick_cnt_q;
  logic                     tick;
  state_e                   state_q;
  logic [TcntW-1:0]         tcnt_q;
  logic [3:0]               bcnt_q;
  logic [MAX_DATA_BITS-1:0] data_q;
  logic                     pbit_q, pe_q, fe_q;
  logic [3:0]               nbits_q, nbits_eff;
  logic                     par_en_q, par_odd_q, stop2_q;
  logic                     done_q, done_pe_q, done_fe_q, done_brk_q;
  logic                     fe_now, brk_now;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign tick = (tick_cnt_q == timer_final_value);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  always_comb begin
    nbits_eff = cfg_data_bits;
    if (cfg_data_bits < 4'd5 || 32'(cfg_data_bits) > MAX_DATA_BITS) begin
      nbits_eff = 4'(MAX_DATA_BITS);
    end
  end

  // Stop sample under evaluation folded into the accumulated framing/break status.
  assign fe_now  = fe_q | ~rx_s;
  assign brk_now = fe_now && (data_q == '0) && !pbit_q;
  assign busy    = (state_q != StIdle);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      tcnt_q     <= '0;
      bcnt_q     <= '0;
      data_q     <= '0;
      pbit_q     <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      nbits_q    <= 4'(MAX_DATA_BITS);
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      done_q     <= 1'b0;
      done_pe_q  <= 1'b0;
      done_fe_q  <= 1'b0;
      done_brk_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_q   <= StStart;
            tcnt_q    <= '0;
            data_q    <= '0;
            pbit_q    <= 1'b0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            nbits_q   <= nbits_eff;
            par_en_q  <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
            par_odd_q <= (cfg_parity == 2'b10);
            stop2_q   <= cfg_stop_bits;
          end
        end
        StStart: begin
          if (tick) begin
            if (tcnt_q == TcntHalf) begin
              tcnt_q  <= '0;
              bcnt_q  <= '0;
              state_q <= rx_s ? StIdle : StData;
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
        end
        StData: begin
          if (tick) begin
            if (tcnt_q == TcntLast) begin
              tcnt_q <= '0;
              data_q <= data_q | (MAX_DATA_BITS'(rx_s) << bcnt_q);
              if (bcnt_q == nbits_q - 4'd1) begin
                bcnt_q  <= '0;
                state_q <= par_en_q ? StParity : StStop;
              end else begin
                bcnt_q <= bcnt_q + 4'd1;
              end
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
        end
        StParity: begin
          if (tick) begin
            if (tcnt_q == TcntLast) begin
              tcnt_q  <= '0;
              pbit_q  <= rx_s;
              pe_q    <= (^data_q) ^ rx_s ^ par_odd_q;
              state_q <= StStop;
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
        end
        StStop: begin
          if (tick) begin
            if (tcnt_q == TcntLast) begin
              tcnt_q <= '0;
              fe_q   <= fe_now;
              if (bcnt_q == {3'b000, stop2_q}) begin
                done_q     <= 1'b1;
                done_pe_q  <= pe_q;
                done_fe_q  <= fe_now;
                done_brk_q <= brk_now;
                state_q    <= brk_now ? StBrkWait : StIdle;
              end else begin
                bcnt_q <= bcnt_q + 4'd1;
              end
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
        end
        StBrkWait: begin
          if (rx_s) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data        <= '0;
      r_valid       <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      break_detect  <= 1'b0;
      overrun       <= 1'b0;
    end else if (done_q && (!r_valid || r_ready)) begin
      r_data        <= data_q;
      r_valid       <= 1'b1;
      parity_error  <= done_pe_q;
      framing_error <= done_fe_q;
      break_detect  <= done_brk_q;
      overrun       <= 1'b0;
    end else if (done_q) begin
      overrun <= 1'b1;
    end else if (r_valid && r_ready) begin
      r_valid       <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      break_detect  <= 1'b0;
      overrun       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: formats, parity, glitch, framing/break, overrun, reset, latency.
module tb_uart_rx_cfg;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] timer_final_value = '0;
  logic [3:0]  cfg_data_bits = 4'd8;
  logic [1:0]  cfg_parity = 2'b00;
  logic        cfg_stop_bits = 1'b0;
  logic        rx = 1'b1;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_ready = 1'b1;
  logic        parity_error, framing_error, break_detect, overrun, busy;

  int n_checks = 0, n_pass = 0;
  int cyc = 0, n_words = 0, n_vcyc = 0, last_t = 0, t_fall = 0, bp = 16;
  int w0, v0;
  logic [7:0] last_data = '0;
  logic       last_pe = 1'b0, last_fe = 1'b0, last_brk = 1'b0;

  uart_rx_cfg #(.MAX_DATA_BITS(8), .OVERSAMPLE(16), .TIMER_BITS(11)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .timer_final_value(timer_final_value),
    .cfg_data_bits    (cfg_data_bits),
    .cfg_parity       (cfg_parity),
    .cfg_stop_bits    (cfg_stop_bits),
    .rx               (rx),
    .r_data           (r_data),
    .r_valid          (r_valid),
    .r_ready          (r_ready),
    .parity_error     (parity_error),
    .framing_error    (framing_error),
    .break_detect     (break_detect),
    .overrun          (overrun),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Records every accepted word and counts cycles with r_valid high.
  always @(negedge clk) begin
    if (reset_n && r_valid) begin
      n_vcyc <= n_vcyc + 1;
      if (r_ready) begin
        n_words   <= n_words + 1;
        last_data <= r_data;
        last_pe   <= parity_error;
        last_fe   <= framing_error;
        last_brk  <= break_detect;
        last_t    <= cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input logic val, input int n);
    rx = val;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input bit has_par,
                            input bit pbit, input int ns, input bit stop_val);
    t_fall = cyc;
    drive(1'b0, bp);
    for (int i = 0; i < nb; i++) drive(d[i], bp);
    if (has_par) drive(pbit, bp);
    for (int i = 0; i < ns; i++) drive(stop_val, bp);
    rx = 1'b1;
  endtask

  task automatic set_cfg(input logic [3:0] nb, input logic [1:0] par, input logic st2);
    cfg_data_bits = nb;
    cfg_parity    = par;
    cfg_stop_bits = st2;
  endtask

  initial begin
    idle(3);
    check("reset_outputs", {r_data, r_valid, parity_error, framing_error, break_detect,
                            overrun, busy}, 0);
    reset_n = 1'b1;
    idle(5);

    // 1: 8N1 0xA5, tick every clock
    w0 = n_words; v0 = n_vcyc;
    send_frame(8'hA5, 8, 0, 0, 1, 1);
    idle(20);
    check("t1_words", n_words - w0, 1);
    check("t1_valid_cycles", n_vcyc - v0, 1);
    check("t1_data", last_data, 8'hA5);
    check("t1_flags", {last_pe, last_fe, last_brk}, 0);
    check("t1_latency", (last_t - t_fall >= 155) && (last_t - t_fall <= 157), 1);
    check("t1_busy", busy, 0);

    // 2: 7E2, 0x35 has four ones so even parity bit is 0
    set_cfg(4'd7, 2'b01, 1'b1);
    send_frame(8'h35, 7, 1, 1, 2, 1);
    idle(20);
    check("t2_data", last_data, 8'h35);
    check("t2_pe_bad", last_pe, 1);
    check("t2_fe", last_fe, 0);
    send_frame(8'h35, 7, 1, 0, 2, 1);
    idle(20);
    check("t2_pe_good", last_pe, 0);

    // odd parity, 5 bits: 0x13 has three ones so odd parity bit is 0
    set_cfg(4'd5, 2'b10, 1'b0);
    send_frame(8'h13, 5, 1, 0, 1, 1);
    idle(20);
    check("odd_data", last_data, 8'h13);
    check("odd_pe_good", last_pe, 0);
    send_frame(8'h13, 5, 1, 1, 1, 1);
    idle(20);
    check("odd_pe_bad", last_pe, 1);

    // out-of-range width clamps to 8
    set_cfg(4'd3, 2'b11, 1'b0);
    send_frame(8'hC3, 8, 0, 0, 1, 1);
    idle(20);
    check("clamp_data", last_data, 8'hC3);
    check("clamp_flags", {last_pe, last_fe}, 0);

    // 3: glitch
    set_cfg(4'd8, 2'b00, 1'b0);
    w0 = n_words; v0 = n_vcyc;
    drive(1'b0, 4);
    rx = 1'b1;
    check("t3_busy_high", busy, 1);
    idle(20);
    check("t3_busy_low", busy, 0);
    check("t3_no_valid", n_vcyc - v0, 0);

    // 4: framing error, then break
    send_frame(8'h3C, 8, 0, 0, 1, 0);
    idle(40);
    check("t4_data", last_data, 8'h3C);
    check("t4_fe", last_fe, 1);
    check("t4_brk", last_brk, 0);
    check("t4_busy", busy, 0);
    w0 = n_words;
    drive(1'b0, 300);
    check("t4b_busy_held", busy, 1);
    check("t4b_words", n_words - w0, 1);
    check("t4b_word", {last_data, last_fe, last_brk}, {8'h00, 2'b11});
    rx = 1'b1;
    idle(10);
    check("t4b_busy_low", busy, 0);
    check("t4b_no_second", n_words - w0, 1);

    // 5: overrun
    r_ready = 1'b0;
    send_frame(8'h11, 8, 0, 0, 1, 1);
    send_frame(8'h22, 8, 0, 0, 1, 1);
    idle(10);
    check("t5_valid", r_valid, 1);
    check("t5_data", r_data, 8'h11);
    check("t5_overrun", overrun, 1);
    r_ready = 1'b1;
    @(negedge clk); #1;
    r_ready = 1'b0;
    check("t5_valid_clr", r_valid, 0);
    check("t5_overrun_clr", overrun, 0);
    r_ready = 1'b1;
    idle(5);

    // 6: reset mid-frame during data bit 3 of 0x5A
    w0 = n_words;
    drive(1'b0, bp);
    drive(1'b0, bp);
    drive(1'b1, bp);
    drive(1'b0, bp);
    drive(1'b1, 8);
    check("t6_busy_pre", busy, 1);
    reset_n = 1'b0;
    #1;
    check("t6_reset_outputs", {r_data, r_valid, parity_error, framing_error, break_detect,
                               overrun, busy}, 0);
    rx = 1'b1;
    idle(5);
    reset_n = 1'b1;
    idle(40);
    check("t6_no_word", n_words - w0, 0);
    check("t6_busy", busy, 0);
    send_frame(8'h5A, 8, 0, 0, 1, 1);
    idle(20);
    check("t6_data", last_data, 8'h5A);
    check("t6_flags", {last_pe, last_fe, last_brk}, 0);

    // 6b: slower tick, latency scales by four
    timer_final_value = 11'd3;
    bp = 64;
    v0 = n_vcyc;
    send_frame(8'hA5, 8, 0, 0, 1, 1);
    idle(40);
    check("t6b_data", last_data, 8'hA5);
    check("t6b_valid_cycles", n_vcyc - v0, 1);
    check("t6b_latency", (last_t - t_fall >= 608) && (last_t - t_fall <= 613), 1);
    check("t6b_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
